// File: rtl/can_rx_frame_fifo.sv
// can_rx_frame_fifo: reassembles the byte-per-cycle CAN receive stream into
// whole frames (ID, IDE, length, up to 8 data bytes) and buffers them in a
// small register-array FIFO with a valid/ready output. Frames completing
// while the FIFO is full are dropped and counted.
module can_rx_frame_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  logic [7:0]            in_data,
   input  logic [28:0]           in_id,
   input  logic                  in_ide,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [28:0]           out_id,
   output logic                  out_ide,
   output logic [3:0]            out_len,
   output logic [63:0]           out_data,
   output logic                  overflow,
   output logic [CNT_W-1:0]      drop_cnt,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // ---------------- frame assembly ----------------
   logic [3:0]  acnt;        // bytes collected so far, saturates at 8
   logic [28:0] asm_id;
   logic        asm_ide;
   logic [63:0] asm_data;

   // Frame as it would look including the byte on the input this cycle.
   logic [63:0] base_data;
   logic [63:0] frame_data;
   logic [28:0] frame_id;
   logic        frame_ide;
   logic [3:0]  frame_len;

   // The first byte of a frame starts from a clean shift register and takes
   // ID/IDE straight from the input; later bytes reuse the latched values.
   assign base_data = (acnt == 4'd0) ? 64'd0 : asm_data;
   assign frame_id  = (acnt == 4'd0) ? in_id  : asm_id;
   assign frame_ide = (acnt == 4'd0) ? in_ide : asm_ide;
   assign frame_len = (acnt >= 4'd8) ? 4'd8 : acnt + 4'd1;

   // Byte slot gi (slot 0 at the top) takes the input byte when acnt points
   // at it; once acnt has reached 8 no slot matches and the byte is lost.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_slot
         assign frame_data[63-8*gi -: 8] =
            (acnt == 4'(gi)) ? in_data : base_data[63-8*gi -: 8];
      end
   endgenerate

   // Accumulate bytes; a last byte returns the counter to the start.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acnt     <= 4'd0;
         asm_id   <= 29'd0;
         asm_ide  <= 1'b0;
         asm_data <= 64'd0;
      end else if (in_valid) begin
         asm_id   <= frame_id;
         asm_ide  <= frame_ide;
         asm_data <= frame_data;
         if (in_last)
            acnt <= 4'd0;
         else if (acnt != 4'd8)
            acnt <= acnt + 4'd1;
      end
   end

   // ---------------- frame FIFO ----------------
   logic [28:0] mem_id   [DEPTH];
   logic        mem_ide  [DEPTH];
   logic [3:0]  mem_len  [DEPTH];
   logic [63:0] mem_data [DEPTH];

   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                empty;
   logic                full;
   logic                pop;
   logic                commit;
   logic                accept;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign pop    = out_valid & out_ready;
   assign commit = in_valid & in_last;
   // A pop in the same cycle frees the slot the new frame needs.
   assign accept = commit & (~full | pop);

   assign out_valid = ~empty;
   assign out_id    = mem_id[rd_ptr[DEPTH_LOG2-1:0]];
   assign out_ide   = mem_ide[rd_ptr[DEPTH_LOG2-1:0]];
   assign out_len   = mem_len[rd_ptr[DEPTH_LOG2-1:0]];
   assign out_data  = mem_data[rd_ptr[DEPTH_LOG2-1:0]];
   assign level     = wr_ptr - rd_ptr;

   // Storage is reset so the head outputs read 0 (never X) before any write.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_id[i]   <= 29'd0;
            mem_ide[i]  <= 1'b0;
            mem_len[i]  <= 4'd0;
            mem_data[i] <= 64'd0;
         end
      end else if (accept) begin
         mem_id[wr_ptr[DEPTH_LOG2-1:0]]   <= frame_id;
         mem_ide[wr_ptr[DEPTH_LOG2-1:0]]  <= frame_ide;
         mem_len[wr_ptr[DEPTH_LOG2-1:0]]  <= frame_len;
         mem_data[wr_ptr[DEPTH_LOG2-1:0]] <= frame_data;
      end
   end

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Pulse overflow for one cycle per dropped frame and count drops, saturating.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         overflow <= commit & ~accept;
         if (commit && !accept && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Testbench for can_rx_frame_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based frame model. A second instance with a 2-bit
// drop counter shares the stimulus to exercise counter saturation.
module tb_can_rx_frame_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid, in_last, in_ide, out_ready;
   logic [7:0]  in_data;
   logic [28:0] in_id;

   logic        out_valid, out_ide, overflow;
   logic [28:0] out_id;
   logic [3:0]  out_len;
   logic [63:0] out_data;
   logic [15:0] drop_cnt;
   logic [4:0]  level;

   logic        s_out_valid, s_out_ide, s_overflow;
   logic [28:0] s_out_id;
   logic [3:0]  s_out_len;
   logic [63:0] s_out_data;
   logic [1:0]  s_drop_cnt;
   logic [4:0]  s_level;

   can_rx_frame_fifo #(.DEPTH_LOG2(4), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last),
      .in_data(in_data), .in_id(in_id), .in_ide(in_ide),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_ide(out_ide), .out_len(out_len), .out_data(out_data),
      .overflow(overflow), .drop_cnt(drop_cnt), .level(level));

   can_rx_frame_fifo #(.DEPTH_LOG2(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last),
      .in_data(in_data), .in_id(in_id), .in_ide(in_ide),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_id(s_out_id),
      .out_ide(s_out_ide), .out_len(s_out_len), .out_data(s_out_data),
      .overflow(s_overflow), .drop_cnt(s_drop_cnt), .level(s_level));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [28:0] id;
      logic        ide;
      logic [3:0]  len;
      logic [63:0] data;
   } frame_t;

   // Reference model: frames waiting in the FIFO, bytes of the partial frame.
   frame_t      mq[$];
   logic [7:0]  pb[$];
   logic [28:0] pid;
   logic        pide;
   logic        exp_ovf;
   int          drops;
   int          nchk = 0;
   int          nerr = 0;

   function automatic int sat3(input int n);
      return (n > 3) ? 3 : n;
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, then
   // leave the bench 1 time unit after the edge for sampling.
   task automatic step(input logic v, input logic l, input logic [7:0] d,
                       input logic [28:0] id, input logic ide, input logic rdy);
      frame_t fr;
      bit     pop, commit, acc;
      in_valid = v; in_last = l; in_data = d; in_id = id; in_ide = ide;
      out_ready = rdy;
      pop    = rdy && (mq.size() > 0);
      commit = v && l;
      fr     = '0;
      acc    = 1'b0;
      if (v) begin
         if (pb.size() == 0) begin
            pid  = id;
            pide = ide;
         end
         pb.push_back(d);
      end
      if (commit) begin
         fr.id  = pid;
         fr.ide = pide;
         fr.len = 4'((pb.size() > 8) ? 8 : pb.size());
         for (int i = 0; i < int'(fr.len); i++)
            fr.data[63-8*i -: 8] = pb[i];
         pb.delete();
         acc = (mq.size() < DEPTH) || pop;
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(fr);
      exp_ovf = commit && !acc;
      if (exp_ovf) drops++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 8'h00, 29'h0, 1'b0, rdy);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      rstn = 1'b0;
      #3;
      mq.delete(); pb.delete();
      drops = 0; exp_ovf = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 0; in_last = 0; in_data = 0; in_id = 0; in_ide = 0; out_ready = 0;
      rstn = 1'b0;
      drops = 0; exp_ovf = 0;
      repeat (2) @(posedge clk);
      #1;
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      nchk++; if (level !== 5'd0) begin nerr++; $display("FAIL reset_level got=%0d want=0", level); end
      nchk++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin nerr++; $display("FAIL reset_drop got ovf=%b cnt=%0d want 0/0", overflow, drop_cnt); end
      nchk++; if ({out_id, out_ide, out_len, out_data} !== '0) begin nerr++; $display("FAIL reset_head got id=%h ide=%b len=%0d data=%h want all 0", out_id, out_ide, out_len, out_data); end
      rstn = 1'b1;
      idle(1'b0);
   endtask

   task automatic test_single_std();
      step(1, 0, 8'h11, 29'h123, 0, 1);
      step(1, 0, 8'h22, 29'h0AA, 1, 1);
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL std_early_valid got=%b want=0", out_valid); end
      step(1, 1, 8'h33, 29'h155, 1, 1);
      nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL std_valid got=%b want=1", out_valid); end
      nchk++; if ({out_id, out_ide, out_len, out_data} !== {29'h123, 1'b0, 4'd3, 64'h1122330000000000})
         begin nerr++; $display("FAIL std_frame got id=%h ide=%b len=%0d data=%h want id=123 ide=0 len=3 data=1122330000000000", out_id, out_ide, out_len, out_data); end
      idle(1'b1);
      nchk++; if (out_valid !== 1'b0 || level !== 5'd0) begin nerr++; $display("FAIL std_popped got valid=%b level=%0d want 0/0", out_valid, level); end
   endtask

   task automatic test_long_ext();
      for (int b = 1; b <= 8; b++) step(1, b == 8, 8'(b), 29'h12345678, 1, 0);
      nchk++; if ({out_id, out_ide, out_len, out_data} !== {29'h12345678, 1'b1, 4'd8, 64'h0102030405060708})
         begin nerr++; $display("FAIL ext8_frame got id=%h ide=%b len=%0d data=%h want id=12345678 ide=1 len=8 data=0102030405060708", out_id, out_ide, out_len, out_data); end
      idle(1'b1);
      for (int b = 1; b <= 10; b++) step(1, b == 10, 8'(8'h20 + b), 29'h1ABCDEF0, 1, 0);
      nchk++; if ({out_len, out_data} !== {4'd8, 64'h2122232425262728})
         begin nerr++; $display("FAIL ext10_frame got len=%0d data=%h want len=8 data=2122232425262728", out_len, out_data); end
      idle(1'b1);
   endtask

   task automatic test_fill_overflow();
      for (int k = 0; k < 17; k++) begin
         step(1, 1, 8'(8'h40 + k), 29'(k + 1), 0, 0);
         nchk++; if (level !== 5'(mq.size()) || overflow !== exp_ovf)
            begin nerr++; $display("FAIL fill_%0d got level=%0d ovf=%b want level=%0d ovf=%b", k, level, overflow, mq.size(), exp_ovf); end
      end
      nchk++; if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd1)
         begin nerr++; $display("FAIL fill_drop got level=%0d ovf=%b cnt=%0d want 16/1/1", level, overflow, drop_cnt); end
      idle(1'b0);
      nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL fill_ovf_pulse got=%b want=0", overflow); end
      for (int k = 0; k < 16; k++) begin
         nchk++; if (out_valid !== 1'b1 || out_id !== 29'(k + 1) || out_data[63:56] !== 8'(8'h40 + k) || out_len !== 4'd1)
            begin nerr++; $display("FAIL drain_%0d got valid=%b id=%h len=%0d b0=%h want 1/%h/1/%h", k, out_valid, out_id, out_len, out_data[63:56], k + 1, 8'h40 + k); end
         idle(1'b1);
      end
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL drain_empty got valid=%b want=0", out_valid); end
   endtask

   task automatic test_simul_full();
      for (int k = 0; k < 16; k++) step(1, 1, 8'(k), 29'(8'h60 + k), 0, 0);
      step(1, 1, 8'hEE, 29'h7FF, 0, 1);
      nchk++; if (overflow !== 1'b0 || level !== 5'd16)
         begin nerr++; $display("FAIL simul_full got ovf=%b level=%0d want 0/16", overflow, level); end
      while (mq.size() > 0) begin
         nchk++; if ({out_id, out_ide, out_len, out_data} !== mq[0])
            begin nerr++; $display("FAIL simul_drain got %h want %h", {out_id, out_ide, out_len, out_data}, mq[0]); end
         idle(1'b1);
      end
   endtask

   task automatic test_gap_reset();
      step(1, 0, 8'hAA, 29'h321, 0, 0);
      repeat (3) idle(1'b0);
      step(1, 1, 8'hBB, 29'h000, 1, 0);
      nchk++; if (out_len !== 4'd2 || out_data[63:48] !== 16'hAABB || out_id !== 29'h321 || out_ide !== 1'b0)
         begin nerr++; $display("FAIL gap_frame got len=%0d data=%h id=%h ide=%b want 2/AABB.../321/0", out_len, out_data, out_id, out_ide); end
      idle(1'b1);
      step(1, 0, 8'h55, 29'h10, 0, 0);
      step(1, 0, 8'h66, 29'h10, 0, 0);
      do_reset();
      step(1, 1, 8'hCC, 29'h0AB, 0, 0);
      nchk++; if (out_valid !== 1'b1 || out_len !== 4'd1 || out_data !== 64'hCC00000000000000 || drop_cnt !== 16'd0)
         begin nerr++; $display("FAIL reset_mid got valid=%b len=%0d data=%h cnt=%0d want 1/1/CC00000000000000/0", out_valid, out_len, out_data, drop_cnt); end
      idle(1'b1);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 16; k++) step(1, 1, 8'(k), 29'(k), 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 8'hF0, 29'h1, 0, 0);
         nchk++; if (overflow !== 1'b1 || s_overflow !== 1'b1)
            begin nerr++; $display("FAIL sat_ovf_%0d got %b/%b want 1/1", k, overflow, s_overflow); end
         nchk++; if (s_drop_cnt !== 2'(sat3(drops)) || drop_cnt !== 16'(drops))
            begin nerr++; $display("FAIL sat_cnt_%0d got %0d/%0d want %0d/%0d", k, s_drop_cnt, drop_cnt, sat3(drops), drops); end
      end
      nchk++; if (s_drop_cnt !== 2'd3 || drop_cnt !== 16'd5)
         begin nerr++; $display("FAIL sat_final got %0d/%0d want 3/5", s_drop_cnt, drop_cnt); end
      while (mq.size() > 0) idle(1'b1);
   endtask

   task automatic test_random();
      int len;
      bit rdy;
      for (int f = 0; f < 200; f++) begin
         len = $urandom_range(1, 11);
         for (int b = 0; b < len; b++) begin
            rdy = ((f / 40) % 2 == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 5) == 0) idle(rdy);
            else step(1, b == len - 1, 8'($urandom), 29'($urandom), 1'($urandom), rdy);
            if ($urandom_range(0, 5) == 0 && b == len - 1) b--;
            nchk++; if (out_valid !== (mq.size() > 0) || level !== 5'(mq.size()))
               begin nerr++; $display("FAIL rand_level got valid=%b level=%0d want %0d", out_valid, level, mq.size()); end
            if (mq.size() > 0) begin
               nchk++; if ({out_id, out_ide, out_len, out_data} !== mq[0])
                  begin nerr++; $display("FAIL rand_head got %h want %h", {out_id, out_ide, out_len, out_data}, mq[0]); end
            end
            nchk++; if (overflow !== exp_ovf || drop_cnt !== 16'(drops) || s_drop_cnt !== 2'(sat3(drops)))
               begin nerr++; $display("FAIL rand_drop got ovf=%b cnt=%0d scnt=%0d want %b/%0d/%0d", overflow, drop_cnt, s_drop_cnt, exp_ovf, drops, sat3(drops)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_std();
      test_long_ext();
      test_fill_overflow();
      test_simul_full();
      test_gap_reset();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/can_rx_frame_fifo.md
Name: can_rx_frame_fifo

Overview:
- Downstream of the CAN controller top's receive byte stream.
- Reassembles the unbuffered byte-per-cycle RX output (valid/last/data/id/ide) into whole frames: ID, IDE, length and up to 8 data bytes.
- Buffers the frames in a small frame FIFO and presents them to the user logic through a valid/ready handshake.
- Frames that arrive while the FIFO is full are dropped and counted.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in frames; depth = 2^DEPTH_LOG2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, single clock domain.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  one received data byte is valid.
- in_last  in  1  marks the final byte of a frame; qualified by in_valid.
- in_data  in  8  received data byte.
- in_id  in  29  frame ID (11-bit IDs occupy [10:0]).
- in_ide  in  1  1 = extended 29-bit ID, 0 = standard ID.
- out_valid  out  1  a frame is available at the head of the FIFO.
- out_ready  in  1  user accepts the head frame.
- out_id  out  29  head frame ID.
- out_ide  out  1  head frame IDE.
- out_len  out  4  head frame byte count, 1..8.
- out_data  out  64  head frame bytes; first-received byte in [63:56]; unused low bytes are 0.
- overflow  out  1  one-cycle pulse when a completed frame is dropped.
- drop_cnt  out  CNT_W  saturating count of dropped frames.
- level  out  DEPTH_LOG2+1  number of frames stored, 0..depth.

Behaviour:
- Reset (async, rstn=0):
  - Clears the assembly state and byte counter (acnt=0).
  - Clears the FIFO pointers, level and drop_cnt.
  - All outputs read 0, including out_valid=0 and overflow=0.
  - Reset mid-frame discards the partial frame. Bytes arriving after release before the next in_last start a fresh frame.
- Assembly (in_valid=1):
  - acnt==0: latch in_id/in_ide and clear the data shift register. ID and IDE come from the first byte only; later changes within the frame are ignored.
  - acnt<8: place the byte at position acnt (byte 0 at [63:56]) and increment acnt.
  - acnt==8: discard the byte. acnt saturates, and the frame length stays 8.
  - Gaps in in_valid within a frame are allowed; assembly state is held across them.
- Commit (in_valid & in_last):
  - The frame is {id, ide, len=acnt+1 (capped at 8), data including the current byte}. acnt returns to 0.
  - The frame is accepted when level<depth, or when level==depth and (out_valid & out_ready) in the same cycle. A simultaneous pop frees the slot.
  - If not accepted:
    - The frame is dropped and overflow=1 for exactly that next cycle.
    - drop_cnt increments, saturating at all-ones.
    - FIFO contents are unchanged.
- FIFO:
  - Register-array storage with combinational head read, so out_* change only at clock edges.
  - Commit latency: a frame committed on the in_last edge is visible with out_valid=1 after that edge (first-word fall-through, 1 cycle).
  - Pop on out_valid & out_ready; the next frame (or out_valid=0) appears after the edge.
  - out_id/out_ide/out_len/out_data are stable while out_valid=1 and out_ready=0.
  - Pointers are DEPTH_LOG2+1 bits with wrap-bit full/empty detection and wrap modulo 2*depth.
  - level is +1 on commit-only, -1 on pop-only, unchanged when both occur in the same cycle.
- The input side has no backpressure: in_* is never stalled. Loss happens only at frame granularity via a drop.
- out_* outputs are don't-care-safe when out_valid=0, but are driven to the entry contents, never X.

Test Plan:
- Single standard frame: id=0x123, ide=0, bytes 11,22,33 with last on 33, out_ready=1 → out_valid for 1 cycle after commit; out_len=3, out_data=0x112233_0000000000, out_id=0x123.
- Full 8-byte extended frame: id=0x12345678, ide=1, bytes 01..08 back-to-back → out_len=8, out_data=0x0102030405060708, out_ide=1. Then 10 bytes with last on the 10th → out_len=8, bytes 9–10 discarded.
- Fill and overflow: out_ready=0, 16 one-byte frames → level=16. The 17th frame gives overflow pulse, drop_cnt=1, level=16. Draining returns frames 1..16 in order with the 17th absent.
- Simultaneous commit and pop at full: level=16, out_ready=1 in the in_last cycle → no drop, level stays 16, the new frame appears last.
- Gapped input plus mid-frame reset: bytes AA,(idle 3 cycles),BB-last → out_len=2, out_data[63:48]=0xAABB. Separately, rstn pulsed after 2 bytes, then 1 byte CC-last → out_len=1, out_data[63:56]=0xCC, drop_cnt=0.
- Drop counter saturation with CNT_W=2: 5 dropped frames → drop_cnt=3, with an overflow pulse on each drop.
